// File: rtl/fb_port_arbiter.sv
// Trace RAM port arbiter: one owner per cycle among a forced write, the display read,
// the trace/dot writer and the built-in screen-clear engine.
module fb_port_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 3,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_miss,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_data,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {StIdle, StClear, StDone} clr_state_e;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0] clr_color_q, clr_color_d;
  logic [7:0]        starve_q, starve_d;
  logic              rd_valid_q, rd_valid_d;

  logic force_wr, gnt_wr, gnt_rd, gnt_clr;

  always_comb begin
    force_wr = wr_req && ({24'd0, starve_q} >= STARVE_LIMIT);
    gnt_wr   = force_wr || (wr_req && !rd_req);
    gnt_rd   = rd_req && !force_wr;
    gnt_clr  = (state_q == StClear) && !rd_req && !wr_req;
  end

  // RAM port mux; the idle cycle parks on the display address.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = rd_addr;
    ram_din  = '0;
    if (gnt_wr) begin
      ram_we   = 1'b1;
      ram_addr = wr_addr;
      ram_din  = wr_data;
    end else if (gnt_rd) begin
      ram_addr = rd_addr;
    end else if (gnt_clr) begin
      ram_we   = 1'b1;
      ram_addr = clr_addr_q;
      ram_din  = clr_color_q;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!wr_req || gnt_wr) begin
      starve_d = 8'd0;
    end else if (starve_q != 8'hFF) begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    unique case (state_q)
      StIdle: begin
        if (clr_start) begin
          clr_color_d = clr_data;
          clr_addr_d  = '0;
          state_d     = StClear;
        end
      end
      StClear: begin
        // Stalled cycles simply hold the address, so nothing is skipped.
        if (gnt_clr) begin
          clr_addr_d = clr_addr_q + 1'b1;
          if (clr_addr_q == {ADDR_W{1'b1}}) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign rd_valid_d = gnt_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      clr_addr_q  <= '0;
      clr_color_q <= '0;
      starve_q    <= 8'd0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      starve_q    <= starve_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign rd_data  = ram_dout;
  assign rd_valid = rd_valid_q;
  assign rd_miss  = force_wr && rd_req;
  assign wr_ack   = gnt_wr;
  assign clr_busy = (state_q == StClear);
  assign clr_done = (state_q == StDone);

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: behavioural RAM plus an owner/shadow-memory model checked every
// cycle, with directed literal checks pinning reads, writes, starvation, clears and reset.
module tb_fb_port_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 3;
  localparam int LIM  = 15;
  localparam int SIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req, rd_valid, rd_miss;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_req, wr_ack;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          clr_start, clr_busy, clr_done;
  logic [DW-1:0] clr_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_miss(rd_miss),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .clr_start(clr_start), .clr_data(clr_data), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port synchronous RAM, read-before-write; pre_en is a bench-side preload port.
  logic [DW-1:0] mem [SIZE] = '{default: '0};
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the RAM this cycle, and what the RAM must hold.
  logic [DW-1:0] shadow [SIZE] = '{default: '0};
  int            m_phase, m_pos, m_color, m_starve, own, e_addr, e_din;
  bit            m_rd_pend, forced, e_we;
  logic [DW-1:0] m_rd_data;

  initial begin : model
    m_phase = 0; m_pos = 0; m_color = 0; m_starve = 0; m_rd_pend = 0; m_rd_data = '0;
    forever begin
      @(negedge clk);
      if (pre_en) shadow[pre_addr] = pre_data;
      if (!rst_n) begin
        m_phase = 0; m_pos = 0; m_color = 0; m_starve = 0; m_rd_pend = 0;
        chk("m_rst_busy", 32'(clr_busy), 32'd0);
        chk("m_rst_done", 32'(clr_done), 32'd0);
        chk("m_rst_valid", 32'(rd_valid), 32'd0);
      end else begin
        forced = wr_req && (m_starve >= LIM);
        if (wr_req && (forced || !rd_req)) own = 2;
        else if (rd_req) own = 1;
        else if (m_phase == 1) own = 3;
        else own = 0;
        e_we   = (own >= 2);
        e_addr = (own == 2) ? int'(wr_addr) : (own == 3) ? m_pos : int'(rd_addr);
        e_din  = (own == 2) ? int'(wr_data) : m_color;
        chk("m_ram_we", 32'(ram_we), 32'(e_we));
        chk("m_ram_addr", 32'(ram_addr), 32'(e_addr));
        if (e_we) chk("m_ram_din", 32'(ram_din), 32'(e_din));
        chk("m_wr_ack", 32'(wr_ack), 32'(own == 2));
        chk("m_rd_miss", 32'(rd_miss), 32'(forced && rd_req));
        chk("m_clr_busy", 32'(clr_busy), 32'(m_phase == 1));
        chk("m_clr_done", 32'(clr_done), 32'(m_phase == 2));
        chk("m_rd_valid", 32'(rd_valid), 32'(m_rd_pend));
        if (m_rd_pend) chk("m_rd_data", 32'(rd_data), 32'(m_rd_data));
        // advance to the next cycle
        if (own == 1) m_rd_data = shadow[rd_addr];
        m_rd_pend = (own == 1);
        if (e_we) shadow[e_addr] = DW'(e_din);
        if (!wr_req || own == 2) m_starve = 0;
        else if (m_starve < 255) m_starve++;
        case (m_phase)
          0: if (clr_start) begin m_phase = 1; m_pos = 0; m_color = int'(clr_data); end
          1: if (own == 3) begin m_pos++; if (m_pos == SIZE) m_phase = 2; end
          default: m_phase = 0;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] e);
    rd_req = 1'b1; rd_addr = a;
    step();
    rd_req = 1'b0;
    @(negedge clk);
    chk(name, 32'(rd_data), 32'(e));
    step();
  endtask

  task automatic wait_clear(input string name, input int exp_busy);
    int  busy = 0;
    bit  done = 0;
    for (int i = 0; i < 3 * SIZE && !done; i++) begin
      @(negedge clk);
      if (clr_done) done = 1;
      else if (clr_busy) busy++;
      step();
    end
    chk({name, "_done_seen"}, 32'(done), 32'd1);
    chk({name, "_busy_cycles"}, 32'(busy), 32'(exp_busy));
  endtask

  initial begin : stim
    int  busy;
    bit  done, ack;
    rst_n = 1'b0; rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0; wr_data = '0;
    clr_start = 0; clr_data = '0; pre_en = 0; pre_addr = '0; pre_data = '0;
    step();
    pre_en = 1'b1; pre_addr = AW'('h234); pre_data = 3'b101;
    step();
    pre_en = 1'b0;
    @(negedge clk);
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    chk("reset_ram_addr", 32'(ram_addr), 32'd0);
    chk("reset_clr_busy", 32'(clr_busy), 32'd0);
    chk("reset_wr_ack", 32'(wr_ack), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Plain read of preloaded data.
    rd_req = 1'b1; rd_addr = AW'('h234);
    @(negedge clk);
    chk("read_addr", 32'(ram_addr), 32'h234);
    chk("read_we", 32'(ram_we), 32'd0);
    step();
    rd_req = 1'b0;
    @(negedge clk);
    chk("read_valid", 32'(rd_valid), 32'd1);
    chk("read_data", 32'(rd_data), 32'd5);
    step();

    // Uncontested write, then read it back.
    wr_req = 1'b1; wr_addr = AW'('hA0B); wr_data = 3'b011;
    @(negedge clk);
    chk("write_we", 32'(ram_we), 32'd1);
    chk("write_ack", 32'(wr_ack), 32'd1);
    step();
    wr_req = 1'b0;
    read_check("write_readback", AW'('hA0B), 3'b011);

    // Starvation: LIM denials, then the write is forced through.
    rd_req = 1'b1; rd_addr = AW'('h10); wr_req = 1'b1; wr_addr = AW'('h11); wr_data = 3'b110;
    for (int i = 0; i < LIM; i++) begin
      @(negedge clk);
      chk("starve_denied", 32'(wr_ack), 32'd0);
      step();
    end
    @(negedge clk);
    chk("forced_ack", 32'(wr_ack), 32'd1);
    chk("forced_miss", 32'(rd_miss), 32'd1);
    step();
    wr_req = 1'b0;
    @(negedge clk);
    chk("forced_no_valid", 32'(rd_valid), 32'd0);
    step();
    @(negedge clk);
    chk("reads_resume", 32'(rd_valid), 32'd1);
    step();
    rd_req = 1'b0;
    read_check("forced_readback", AW'('h11), 3'b110);

    // Full clear with no other traffic.
    clr_start = 1'b1; clr_data = 3'b111;
    step();
    clr_start = 1'b0; clr_data = '0;
    wait_clear("clr_free", SIZE);
    read_check("clr_lo", AW'(0), 3'b111);
    read_check("clr_mid", AW'(SIZE / 2), 3'b111);
    read_check("clr_hi", AW'(SIZE - 1), 3'b111);

    // Clear against reads on every other cycle; a second start mid-sweep is ignored.
    clr_start = 1'b1; clr_data = 3'b010;
    step();
    busy = 0; done = 0;
    for (int k = 0; k < 3 * SIZE && !done; k++) begin
      rd_req    = (k % 2 == 0);
      rd_addr   = AW'($urandom);
      clr_start = (k == 100);
      clr_data  = (k == 100) ? 3'b101 : 3'b010;
      @(negedge clk);
      if (clr_done) done = 1;
      else if (clr_busy) busy++;
      step();
    end
    rd_req = 1'b0; clr_start = 1'b0;
    chk("clr_shared_done_seen", 32'(done), 32'd1);
    chk("clr_shared_busy_cycles", 32'(busy), 32'(2 * SIZE));
    read_check("clr_shared_lo", AW'(0), 3'b010);
    read_check("clr_shared_mid", AW'(SIZE / 2), 3'b010);
    read_check("clr_shared_hi", AW'(SIZE - 1), 3'b010);

    // Reset part way through a clear, then restart from address 0.
    clr_start = 1'b1; clr_data = 3'b011;
    step();
    clr_start = 1'b0;
    repeat (SIZE / 4) step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy_now", 32'(clr_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(clr_done), 32'd0);
      step();
    end
    rst_n = 1'b1;
    step();
    clr_start = 1'b1; clr_data = 3'b001;
    step();
    clr_start = 1'b0;
    @(negedge clk);
    chk("restart_addr", 32'(ram_addr), 32'd0);
    chk("restart_we", 32'(ram_we), 32'd1);
    step();
    wait_clear("clr_restart", SIZE - 1);
    read_check("restart_quarter", AW'(SIZE / 4), 3'b001);

    // Random traffic; the writer holds its request until acknowledged.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      ack = wr_ack;
      @(posedge clk);
      #1;
      if (!wr_req || ack) begin
        wr_req  = ($urandom_range(0, 2) != 0);
        wr_addr = AW'($urandom);
        wr_data = DW'($urandom);
      end
      rd_req    = ($urandom_range(0, 9) < ((i < 2000) ? 9 : 4));
      rd_addr   = AW'($urandom);
      clr_start = ($urandom_range(0, 499) == 0);
      clr_data  = DW'($urandom);
    end
    rd_req = 1'b0; wr_req = 1'b0; clr_start = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Time-shares the 64K x 3 single-port synchronous trace RAM among three requesters, so the RAM has exactly one owner per cycle.
- Requester 1: the display read path, addressed by the scan position inside the 256x256 box.
- Requester 2: the trace/dot writer, using a req/ack handshake.
- Requester 3: a built-in screen-clear engine that sweeps every address with one colour.
- The block sits between the bitmap generator logic and the RAM and owns the RAM's we/addr/din.

Parameters:
- ADDR_W, 16, RAM address width; the clear sweep covers 0 .. 2^ADDR_W-1.
- DATA_W, 3, RAM data width (one bit per R/G/B).
- STARVE_LIMIT, 15, consecutive cycles a pending write may lose to reads before it is forced through. Legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- rd_req  in  1  display read request, level; sampled each cycle.
- rd_addr  in  ADDR_W  display read address.
- rd_data  out  DATA_W  read data; wired directly from ram_dout.
- rd_valid  out  1  rd_data is valid for the read granted in the previous cycle.
- rd_miss  out  1  one-cycle pulse when a rd_req was denied by a forced write.
- wr_req  in  1  write request; held high until wr_ack.
- wr_addr  in  ADDR_W  write address; stable while wr_req is high.
- wr_data  in  DATA_W  write data; stable while wr_req is high.
- wr_ack  out  1  one-cycle pulse in the cycle the write is issued to the RAM.
- clr_start  in  1  pulse that starts a full clear.
- clr_data  in  DATA_W  fill colour, captured at clr_start.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse after the last address is written.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data; valid one cycle after the address.

Interface: one clock (clk); reset rst_n is asynchronous, active-low.

Behaviour:
- Reset values:
  - rd_valid, rd_miss, wr_ack, clr_busy, clr_done all 0.
  - Clear FSM in IDLE, clear address 0, starvation counter 0, latched clear colour 0.
  - ram_we=0, ram_addr=0, ram_din=0.
- Grant, combinational, one owner per cycle. Priority:
  1. Forced write: wr_req=1 and starve_cnt >= STARVE_LIMIT.
  2. Read: rd_req=1.
  3. Write: wr_req=1.
  4. Clear: FSM in CLEAR.
  5. Idle: ram_we=0, ram_addr=rd_addr.
- Read grant:
  - ram_we=0, ram_addr=rd_addr.
  - rd_valid=1 in the next cycle; rd_data=ram_dout (1-cycle latency).
- Write grant:
  - ram_we=1, ram_addr=wr_addr, ram_din=wr_data, wr_ack=1 in the same cycle.
  - The requester drops wr_req or presents a new write in the next cycle.
  - Back-to-back writes are allowed, one per cycle.
- Starvation counter (8-bit):
  - Increments when wr_req=1 and the write is not granted; saturates at 255.
  - Clears to 0 on a write grant or when wr_req=0.
  - A forced write with rd_req=1 pulses rd_miss in the same cycle and leaves rd_valid=0 in the next cycle.
- Clear FSM:
  - IDLE: clr_start=1 latches clr_data, clears address to 0, moves to CLEAR.
  - CLEAR: clr_busy=1. On each clear grant: ram_we=1, ram_addr=clr_addr, ram_din=latched colour, clr_addr+1.
    - The grant at clr_addr=all-ones moves to DONE; no wrap.
    - Lost cycles stall the sweep without skipping addresses.
  - DONE: one cycle; clr_done=1, clr_busy=0; returns to IDLE.
  - clr_start during CLEAR or DONE is ignored; a later colour change has no effect.
- Simultaneous events:
  - rd_req and wr_req with counter below limit: the read wins.
  - clr_start in the same cycle as a read: the FSM still enters CLEAR; its first write happens on the first free cycle.
- Reset mid-operation:
  - A clear is aborted (FSM to IDLE, no clr_done) and pending acks are lost.
  - The requester re-issues after reset.

Test Plan:
- rd_req=1, rd_addr=0x1234, RAM preloaded 3'b101 -> ram_addr=0x1234, ram_we=0; rd_valid=1 and rd_data=3'b101 on the next cycle.
- wr_req=1, wr_addr=0x0A0B, wr_data=3'b011, rd_req=0 -> ram_we=1 and wr_ack=1 in the same cycle; a subsequent read of 0x0A0B returns 3'b011.
- rd_req held 1 and wr_req=1, STARVE_LIMIT=15 -> write denied 15 cycles, then forced on cycle 16 with wr_ack=1 and rd_miss=1; next cycle rd_valid=0, then reads resume.
- clr_start with clr_data=3'b111, no other traffic -> clr_busy for 65536 cycles, clr_done pulse on cycle 65537; spot reads at 0x0000, 0x8000, 0xFFFF return 3'b111.
- clear running with rd_req active on every other cycle -> the sweep takes 131072 grants' worth of time and writes all 65536 addresses once; a second clr_start mid-sweep is ignored (colour unchanged).
- rst_n low at clr_addr=0x4000 -> clr_busy=0 immediately, no clr_done; a fresh clr_start restarts from 0x0000.
